// File: rtl/temp_bcd_conv_pkg.sv
// Shared types and constants for the temperature-to-BCD converter.
// Optional build macro: TEMP_FAHRENHEIT_EN (Fahrenheit output from LOAD).
package temp_pkg;

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

   localparam int unsigned BCD_DIGITS = 3;

   localparam int F_OFFSET5 = 160;
   localparam int F_MUL     = 9;
   localparam int F_DIV     = 5;

   // Five times the Fahrenheit value: 9*C + 160 (the +32 offset pre-scaled by 5)
   function automatic logic signed [11:0] f5_of(input logic [7:0] c);
      return 12'(int'($signed(c)) * F_MUL + F_OFFSET5);
   endfunction

   // |f5| / 5 with round-half-up on the magnitude
   function automatic logic [11:0] f_mag_of(input logic signed [11:0] f5);
      logic [11:0] a;
      a = f5[11] ? 12'(-f5) : 12'(f5);
      return 12'((a + 12'd2) / 12'(F_DIV));
   endfunction

endpackage

// File: rtl/temp_bcd_conv_add3_step.sv
// One double-dabble iteration: add-3 correction on every BCD nibble >= 5,
// then shift {bcd, mag} left by one bit.
module bcd_add3_step
   import temp_pkg::*;
#(
   parameter int unsigned MAG_W = 9
)(
   input  logic [4*BCD_DIGITS-1:0] bcd_in,
   input  logic [MAG_W-1:0]        mag_in,
   output logic [4*BCD_DIGITS-1:0] bcd_out,
   output logic [MAG_W-1:0]        mag_out
);

   logic [4*BCD_DIGITS-1:0] adj;

   // Correct each digit so the following shift carries properly into the next decade
   always_comb begin
      adj = bcd_in;
      for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
         if (bcd_in[4*i +: 4] >= 4'd5) begin
            adj[4*i +: 4] = bcd_in[4*i +: 4] + 4'd3;
         end
      end
      {bcd_out, mag_out} = {adj, mag_in} << 1;
   end

endmodule

// File: rtl/temp_bcd_conv.sv
// Converts the signed 8-bit temperature reading into sign + three BCD digits
// with a sequential double-dabble. Reconverts on a new reading or on the
// periodic refresh tick. Optional build macro: TEMP_FAHRENHEIT_EN.
module temp_bcd_conv
   import temp_pkg::*;
#(
   parameter int unsigned MAG_W       = 9,
   parameter int unsigned REFRESH_CYC = 20000
)(
   input  logic       clk_200KHz,
   input  logic       rst_n,
   input  logic [7:0] temp_data,
   output logic       sign,
   output logic [3:0] bcd_hundreds,
   output logic [3:0] bcd_tens,
   output logic [3:0] bcd_ones,
   output logic       bcd_valid,
   output logic       busy
);

   localparam int unsigned CNT_W  = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;
   localparam int unsigned ITER_W = (MAG_W > 1) ? $clog2(MAG_W) : 1;
   localparam int unsigned BCD_W  = 4 * BCD_DIGITS;
   localparam logic [CNT_W-1:0]  REFRESH_LAST = CNT_W'((REFRESH_CYC == 0) ? 0 : REFRESH_CYC - 1);
   localparam logic [ITER_W-1:0] ITER_LAST    = ITER_W'(MAG_W - 1);

   state_t             state, state_nxt;
   logic [7:0]         cap, last_seen;
   logic [CNT_W-1:0]   refresh_cnt;
   logic [ITER_W-1:0]  iter;
   logic [BCD_W-1:0]   bcd_acc, bcd_step;
   logic [MAG_W-1:0]   mag, mag_step, ld_mag;
   logic               sign_acc, ld_sign, trigger;

`ifdef TEMP_FAHRENHEIT_EN
   logic signed [11:0] f5;
   logic [11:0]        f_mag;

   // Fahrenheit magnitude/sign of the captured reading, evaluated during LOAD
   always_comb begin
      f5      = f5_of(cap);
      f_mag   = f_mag_of(f5);
      ld_mag  = MAG_W'(f_mag);
      ld_sign = f5[11] && (f_mag != '0);
   end
`else
   logic [7:0] c_abs;

   // Celsius magnitude/sign; -128 maps to an unsigned 128
   always_comb begin
      c_abs   = cap[7] ? 8'(-cap) : cap;
      ld_mag  = MAG_W'(c_abs);
      ld_sign = cap[7] && (c_abs != '0);
   end
`endif

   bcd_add3_step #(.MAG_W(MAG_W)) u_step (
      .bcd_in  (bcd_acc),
      .mag_in  (mag),
      .bcd_out (bcd_step),
      .mag_out (mag_step)
   );

   assign busy = (state != IDLE);

   // State register
   always_ff @(posedge clk_200KHz or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic; a change and a refresh in the same cycle give one trigger
   always_comb begin
      state_nxt = state;
      trigger   = (temp_data != last_seen) ||
                  ((REFRESH_CYC != 0) && (refresh_cnt == REFRESH_LAST));
      case (state)
         IDLE:    if (trigger) state_nxt = LOAD;
         LOAD:    state_nxt = SHIFT;
         SHIFT:   if (iter == ITER_LAST) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Capture, conversion datapath and output registers
   always_ff @(posedge clk_200KHz or negedge rst_n) begin
      if (!rst_n) begin
         cap          <= '0;
         last_seen    <= '0;
         refresh_cnt  <= '0;
         iter         <= '0;
         bcd_acc      <= '0;
         mag          <= '0;
         sign_acc     <= 1'b0;
         sign         <= 1'b0;
         bcd_hundreds <= '0;
         bcd_tens     <= '0;
         bcd_ones     <= '0;
         bcd_valid    <= 1'b0;
      end else begin
         bcd_valid <= (state == DONE);
         case (state)
            IDLE: begin
               if (trigger) begin
                  cap         <= temp_data;
                  last_seen   <= temp_data;
                  refresh_cnt <= '0;
               end else if (REFRESH_CYC != 0) begin
                  refresh_cnt <= refresh_cnt + 1'b1;
               end
            end
            LOAD: begin
               sign_acc <= ld_sign;
               mag      <= ld_mag;
               bcd_acc  <= '0;
               iter     <= '0;
            end
            SHIFT: begin
               bcd_acc <= bcd_step;
               mag     <= mag_step;
               iter    <= iter + 1'b1;
            end
            DONE: begin
               sign         <= sign_acc;
               bcd_hundreds <= bcd_acc[11:8];
               bcd_tens     <= bcd_acc[7:4];
               bcd_ones     <= bcd_acc[3:0];
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_temp_bcd_conv.sv
// Directed, scoreboarded bench for temp_bcd_conv (default and refresh-50 instances).
module tb_temp_bcd_conv;

   logic       clk = 1'b0;
   logic       rst_n, rst_r_n;
   logic [7:0] temp_data, temp_r;
   logic       sign, valid, busy;
   logic [3:0] hun, ten, one;
   logic       sign_r, valid_r, busy_r;
   logic [3:0] hun_r, ten_r, one_r;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;
   int unsigned n_valid = 0;
   int unsigned cyc     = 0;
   logic [12:0] sb[$];
   int unsigned r_stamps[$];
   logic [12:0] e;

   always #5 clk = ~clk;

   temp_bcd_conv dut (
      .clk_200KHz   (clk),
      .rst_n        (rst_n),
      .temp_data    (temp_data),
      .sign         (sign),
      .bcd_hundreds (hun),
      .bcd_tens     (ten),
      .bcd_ones     (one),
      .bcd_valid    (valid),
      .busy         (busy)
   );

   temp_bcd_conv #(.REFRESH_CYC(50)) dut_r (
      .clk_200KHz   (clk),
      .rst_n        (rst_r_n),
      .temp_data    (temp_r),
      .sign         (sign_r),
      .bcd_hundreds (hun_r),
      .bcd_tens     (ten_r),
      .bcd_ones     (one_r),
      .bcd_valid    (valid_r),
      .busy         (busy_r)
   );

   function automatic logic [12:0] model(input logic [7:0] v);
      int   c, m;
      logic s;
`ifdef TEMP_FAHRENHEIT_EN
      int   f;
`endif
      c = int'($signed(v));
`ifdef TEMP_FAHRENHEIT_EN
      f = 9 * c + 160;
      s = (f < 0);
      m = ((f < 0 ? -f : f) + 2) / 5;
`else
      s = (c < 0);
      m = (c < 0) ? -c : c;
`endif
      if (m == 0) s = 1'b0;
      return {s, 4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (valid) begin
         n_valid++;
         chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("result", 32'({sign, hun, ten, one}), 32'(e));
         end
      end
   end

   always @(negedge clk) begin
      if (rst_r_n && valid_r && r_stamps.size() < 8) begin
         r_stamps.push_back(cyc);
         chk("refresh_result", 32'({sign_r, hun_r, ten_r, one_r}), 32'(model(8'h19)));
      end
   end

   task automatic convert(input logic [7:0] v);
      int unsigned start;
      logic [12:0] x;
      x = model(v);
      sb.push_back(x);
      temp_data = v;
      start = n_valid;
      for (int i = 0; i < 40 && n_valid == start; i++) tick;
      chk("conv_done", n_valid - start, 32'd1);
      repeat (3) tick;
      chk("hold", 32'({sign, hun, ten, one}), 32'(x));
      chk("idle_after", 32'(busy), 32'd0);
   endtask

   initial begin
      int unsigned busy_cnt, vcnt, vat, start;
      rst_n     = 1'b0;
      rst_r_n   = 1'b0;
      temp_data = 8'h00;
      temp_r    = 8'h19;
      repeat (3) tick;
      chk("rst_outputs", 32'({sign, hun, ten, one}), 32'd0);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      rst_n   = 1'b1;
      rst_r_n = 1'b1;
      repeat (3) tick;
      chk("no_trigger_on_equal", 32'(busy), 32'd0);

      // 25 degC: latency and pulse shape
      sb.push_back(model(8'h19));
      temp_data = 8'h19;
      busy_cnt = 0; vcnt = 0; vat = 0;
      for (int i = 1; i <= 20; i++) begin
         tick;
         if (busy) busy_cnt++;
         if (valid) begin
            vcnt++;
            if (vat == 0) vat = i;
         end
      end
      chk("busy_cycles", busy_cnt, 32'd11);
      chk("valid_cycles", vcnt, 32'd1);
      chk("valid_latency", vat, 32'd12);

      convert(8'hD8);
      convert(8'h7F);
      convert(8'h80);
      convert(8'hEE);
      convert(8'hFF);
      convert(8'h00);

      // input change during busy: both values are converted, in order
      sb.push_back(model(8'h19));
      sb.push_back(model(8'h1E));
      temp_data = 8'h19;
      start = n_valid;
      repeat (5) tick;
      temp_data = 8'h1E;
      for (int i = 0; i < 60 && n_valid < start + 2; i++) tick;
      chk("two_conversions", n_valid - start, 32'd2);
      repeat (3) tick;
      chk("second_hold", 32'({sign, hun, ten, one}), 32'(model(8'h1E)));

      // reset in the middle of a conversion
      temp_data = 8'h2A;
      start = n_valid;
      repeat (7) tick;
      chk("midconv_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("abort_outputs", 32'({sign, hun, ten, one}), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      temp_data = 8'h00;
      repeat (20) tick;
      chk("abort_no_valid", n_valid - start, 32'd0);
      rst_n = 1'b1;
      repeat (5) tick;
      chk("abort_idle", 32'(busy), 32'd0);
      chk("abort_outputs_after", 32'({sign, hun, ten, one}), 32'd0);
      chk("sb_drained", 32'(sb.size()), 32'd0);

      // periodic refresh on the REFRESH_CYC=50 instance
      for (int i = 0; i < 400 && r_stamps.size() < 3; i++) tick;
      chk("refresh_pulses", 32'(r_stamps.size() >= 3), 32'd1);
      if (r_stamps.size() >= 3) begin
         chk("refresh_period1", r_stamps[1] - r_stamps[0], 32'd61);
         chk("refresh_period2", r_stamps[2] - r_stamps[1], 32'd61);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
